// File: rtl/jericalla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : jericalla_pipe
// Purpose  : Two-stage (EX, WB) register-file / ALU pipeline. Accepts one
//            packed instruction per cycle over a valid/ready handshake,
//            executes NOP / ADD / SUB / LI and writes the result back to the
//            register file. Every written result also appears on DS together
//            with a one-cycle ds_valid strobe.
// Ports    : CLK          clock, rising edge
//            RST          synchronous reset, active-high
//            instr_valid  instruction present on `instruction`
//            instruction  [op(2) | rs1 | rs2 | rd], op in the MSBs
//            instr_ready  instruction accepted on this edge when also valid
//            DS           last written-back result
//            ds_valid     1-cycle pulse, DS updated this cycle
// Options  : BYPASS_EN  when defined, the EX result is forwarded to a
//            dependent operand; otherwise a dependent ADD/SUB stalls for one
//            cycle and picks up the value from the register file.
// Revision : 1.0  initial release
// ============================================================================
module jericalla_pipe #(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 5,
    localparam int INSTR_W = 2 + 3*ADDR_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  DS,
    output logic               ds_valid
);

    localparam int         c_NREG   = 2**ADDR_W;
    localparam logic [1:0] c_OP_NOP = 2'b00;
    localparam logic [1:0] c_OP_ADD = 2'b01;
    localparam logic [1:0] c_OP_SUB = 2'b10;
    localparam logic [1:0] c_OP_LI  = 2'b11;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [1:0]          w_op;
    logic [ADDR_W-1:0]   w_rs1;
    logic [ADDR_W-1:0]   w_rs2;
    logic [ADDR_W-1:0]   w_rd;
    logic [2*ADDR_W-1:0] w_imm;

    assign w_op  = instruction[INSTR_W-1 -: 2];
    assign w_rs1 = instruction[3*ADDR_W-1 -: ADDR_W];
    assign w_rs2 = instruction[2*ADDR_W-1 -: ADDR_W];
    assign w_rd  = instruction[ADDR_W-1:0];
    // LI reuses the two source fields as one immediate
    assign w_imm = instruction[3*ADDR_W-1:ADDR_W];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_rf [c_NREG];

    logic              r_ex_valid;   // EX holds a writing op (ADD/SUB/LI)
    logic [1:0]        r_ex_op;
    logic [ADDR_W-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;

    logic [DATA_W-1:0] r_ds;
    logic              r_ds_valid;

    // ------------------------------------------------------------------
    // EX-stage ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ex_result;

    always_comb begin
        w_ex_result = '0;
        case (r_ex_op)
            c_OP_ADD: w_ex_result = r_ex_a + r_ex_b;
            c_OP_SUB: w_ex_result = r_ex_a - r_ex_b;
            c_OP_LI:  w_ex_result = r_ex_a;
            default:  w_ex_result = '0;
        endcase
    end

    // The EX instruction retires into the RF at the same edge the next
    // instruction is captured, so a source naming its rd sees stale RF
    // data. R0 never counts as a producer.
    logic w_ex_wr;
    logic w_hit1;
    logic w_hit2;

    assign w_ex_wr = r_ex_valid && (r_ex_rd != '0);
    assign w_hit1  = w_ex_wr && (w_rs1 == r_ex_rd);
    assign w_hit2  = w_ex_wr && (w_rs2 == r_ex_rd);

    // ------------------------------------------------------------------
    // Operand fetch and handshake
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic              w_hazard;

`ifdef BYPASS_EN
    // Forwarding gives write-first semantics for the RF write retiring
    // on the capture edge.
    assign w_src1   = (w_rs1 == '0) ? '0 : (w_hit1 ? w_ex_result : r_rf[w_rs1]);
    assign w_src2   = (w_rs2 == '0) ? '0 : (w_hit2 ? w_ex_result : r_rf[w_rs2]);
    assign w_hazard = 1'b0;
`else
    logic w_reads_rf;

    assign w_src1     = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
    assign w_src2     = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
    // Only ADD/SUB read registers; LI and NOP never wait.
    assign w_reads_rf = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
    assign w_hazard   = instr_valid && w_reads_rf && (w_hit1 || w_hit2);
`endif

    assign instr_ready = ~RST & ~w_hazard;

    logic              w_accept;
    logic [DATA_W-1:0] w_opa;

    assign w_accept = instr_valid && instr_ready;
    assign w_opa    = (w_op == c_OP_LI) ? DATA_W'(w_imm) : w_src1;

    // ------------------------------------------------------------------
    // EX register: a non-accepting edge or an accepted NOP loads a bubble
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= c_OP_NOP;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_accept && (w_op != c_OP_NOP);
            r_ex_op    <= w_op;
            r_ex_rd    <= w_rd;
            r_ex_a     <= w_opa;
            r_ex_b     <= w_src2;
        end
    end

    // ------------------------------------------------------------------
    // WB: register file and result port
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rf       <= '{default: '0};
            r_ds       <= '0;
            r_ds_valid <= 1'b0;
        end else if (r_ex_valid) begin
            // R0 stays zero but its result is still reported on DS
            if (r_ex_rd != '0) begin
                r_rf[r_ex_rd] <= w_ex_result;
            end
            r_ds       <= w_ex_result;
            r_ds_valid <= 1'b1;
        end else begin
            r_ds_valid <= 1'b0;
        end
    end

    assign DS       = r_ds;
    assign ds_valid = r_ds_valid;

endmodule
`default_nettype wire
